// File: rtl/conv_window_sequencer.sv
// Purpose : walks a 3x3 window over a zero-padded image held in BRAM, fetching 9 pixels,
//           kicking the convolution unit and writing one result per unpadded pixel.
// Latency : 12+N cycles per window (9 FETCH, 1 DRAIN, 1 CONV, N>=1 WAIT, 1 WRITE).
// Backpr. : none upstream; stalls in WAIT until done_conv (level-sampled).
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - begin one image (sampled in IDLE only)
//   done_conv          - convolution unit finished (looked at in WAIT only)
//   address[14:0]      - BRAM read address into the (IMG_W+2)x(IMG_H+2) padded image
//   shift_right        - load enable for the 72-bit window register (data lags address by 1)
//   start_conv         - one-cycle start pulse to the convolution unit
//   out_we/out_addr    - result strobe and output pixel index r*IMG_W+c
//   busy, done         - busy outside IDLE; done pulses once after the last result
//   state_reg[2:0]     - current state encoding
//   err                - watchdog tripped (only when SEQ_TIMEOUT_EN is defined)
//
// Build option: define SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT cycles and expose err.
module conv_window_sequencer #(
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 128,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        done_conv,
    output logic [14:0] address,
    output logic        shift_right,
    output logic        start_conv,
    output logic        out_we,
    output logic [13:0] out_addr,
    output logic        busy,
    output logic        done,
`ifdef SEQ_TIMEOUT_EN
    output logic        err,
`endif
    output logic [2:0]  state_reg
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_CONV  = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [RW-1:0]   r_q, r_d;
    logic [3:0]      k_q, k_d;
    logic [1:0]      kcol_q, kcol_d;    // k%3 kept as its own counter to avoid a divider
    logic [14:0]     base_q, base_d;    // padded address of window top-left: r*(IMG_W+2)+c
    logic [14:0]     ptr_q, ptr_d;      // address of the pixel being fetched this cycle
    logic [13:0]     oidx_q, oidx_d;    // r*IMG_W+c tracked incrementally
    logic [14:0]     base_nxt;
    logic            last_col;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic            err_q, err_d;
`endif

    assign last_col = (c_q == CW'(IMG_W - 1));
    // Next row starts IMG_W+2 past the current row start; from the last column that is +3.
    assign base_nxt = last_col ? (base_q + 15'd3) : (base_q + 15'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            kcol_q  <= '0;
            base_q  <= '0;
            ptr_q   <= '0;
            oidx_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            k_q     <= k_d;
            kcol_q  <= kcol_d;
            base_q  <= base_d;
            ptr_q   <= ptr_d;
            oidx_q  <= oidx_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`endif

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        r_d         = r_q;
        k_d         = k_q;
        kcol_d      = kcol_q;
        base_d      = base_q;
        ptr_d       = ptr_q;
        oidx_d      = oidx_q;
        shift_right = 1'b0;
        start_conv  = 1'b0;
        out_we      = 1'b0;
        done        = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    c_d     = '0;
                    r_d     = '0;
                    k_d     = '0;
                    kcol_d  = '0;
                    base_d  = '0;
                    ptr_d   = '0;
                    oidx_d  = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                // BRAM data for k-1 arrives this cycle, so k=0 has nothing to shift yet.
                shift_right = (k_q != 4'd0);
                k_d         = k_q + 4'd1;
                if (kcol_q == 2'd2) begin
                    kcol_d = 2'd0;
                    ptr_d  = ptr_q + 15'(IMG_W);   // back 2 columns, down one padded row
                end else begin
                    kcol_d = kcol_q + 2'd1;
                    ptr_d  = ptr_q + 15'd1;
                end
                if (k_q == 4'd8) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                shift_right = 1'b1;
                state_d     = S_CONV;
            end
            S_CONV: begin
                start_conv = 1'b1;
                state_d    = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                wcnt_d     = '0;
`endif
            end
            S_WAIT: begin
                if (done_conv) begin
                    state_d = S_WRITE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
`endif
            end
            S_WRITE: begin
                out_we = 1'b1;
                oidx_d = oidx_q + 14'd1;
                k_d    = '0;
                kcol_d = '0;
                base_d = base_nxt;
                ptr_d  = base_nxt;
                if (last_col) begin
                    c_d = '0;
                    r_d = r_q + RW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
                if (last_col && (r_q == RW'(IMG_H - 1))) state_d = S_FIN;
                else                                     state_d = S_FETCH;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address   = (state_q == S_FETCH) ? ptr_q : 15'd0;
    assign out_addr  = oidx_q;
    assign busy      = (state_q != S_IDLE);
    assign state_reg = state_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: small 4x3 image for full runs, default-size
// instance for the first window, optional watchdog run when SEQ_TIMEOUT_EN is defined.
module tb_conv_window_sequencer;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk, rst_n, start, done_conv;
    logic [14:0] address;
    logic        shift_right, start_conv, out_we, busy, done;
    logic [13:0] out_addr;
    logic [2:0]  state_reg;
`ifdef SEQ_TIMEOUT_EN
    logic        err;
`endif

    logic        b_rst_n, b_start, b_done_conv;
    logic [14:0] b_address;
    logic        b_shift_right, b_start_conv, b_out_we, b_busy, b_done;
    logic [13:0] b_out_addr;
    logic [2:0]  b_state;
`ifdef SEQ_TIMEOUT_EN
    logic        b_err;
`endif

    conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done_conv(done_conv),
        .address(address), .shift_right(shift_right), .start_conv(start_conv),
        .out_we(out_we), .out_addr(out_addr), .busy(busy), .done(done),
`ifdef SEQ_TIMEOUT_EN
        .err(err),
`endif
        .state_reg(state_reg)
    );

    conv_window_sequencer dut_big (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .done_conv(b_done_conv),
        .address(b_address), .shift_right(b_shift_right), .start_conv(b_start_conv),
        .out_we(b_out_we), .out_addr(b_out_addr), .busy(b_busy), .done(b_done),
`ifdef SEQ_TIMEOUT_EN
        .err(b_err),
`endif
        .state_reg(b_state)
    );

    typedef struct {
        int sel;   // 0: small first window, 1: small last window, 2: big first window
        int idx;
        int exp;
    } vec_t;
    vec_t vecs[27];

    int n_cmp = 0;
    int n_fail = 0;
    int n_we = 0, n_done = 0, n_shift = 0, b_shift = 0, cyc = 0, last_we = -1;
    int resp_en = 1;
    int exp_q[$];
    int addr_log[$];
    int big_log[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Convolution-unit model: done_conv high for one cycle, two cycles after start_conv.
    initial begin
        int cd;
        bit armed;
        armed = 0;
        cd = 0;
        done_conv = 0;
        forever begin
            @(negedge clk);
            done_conv = 0;
            if (armed) begin
                if (cd == 1) begin
                    done_conv = (resp_en != 0);
                    armed = 0;
                end else cd--;
            end
            if (start_conv) begin
                armed = 1;
                cd = 2;
            end
        end
    end

    // Monitor / scoreboard consumer.
    initial begin
        int strobes, expv;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                strobes = start_conv + shift_right + out_we + done;
                if (strobes != 0) check("strobe_exclusive", int'(strobes > 1), 0);
                if (state_reg == 3'd1) addr_log.push_back(int'(address));
                if (shift_right) n_shift++;
                if (done) n_done++;
                if (out_we) begin
                    n_we++;
                    expv = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                    check("out_addr", out_addr, expv);
                    if (last_we >= 0) check("window_latency", cyc - last_we, 14);
                    last_we = cyc;
                end
                if (state_reg == 3'd0) last_we = -1;
            end else begin
                last_we = -1;
            end
            if (b_rst_n) begin
                if (b_state == 3'd1) big_log.push_back(int'(b_address));
                if (b_shift_right) b_shift++;
            end
        end
    end

    // mode 0: start pulsed once; 1: start held through the run; 2: random start pulses mid-image
    task automatic run(input int mode, input string tag);
        int we0, done0, sh0, t, base;
        addr_log.delete();
        exp_q.delete();
        for (int i = 0; i < W * H; i++) exp_q.push_back(i);
        we0 = n_we; done0 = n_done; sh0 = n_shift;
        start = 1;
        @(negedge clk);
        check({tag, "_first_state"}, state_reg, 1);
        check({tag, "_first_addr"}, address, 0);
        if (mode == 0) start = 0;
        t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
            if (mode == 2) start = ($urandom_range(0, 3) == 0);
        end
        check({tag, "_done_seen"}, done, 1);
        start = 0;
        @(negedge clk);
        check({tag, "_we_count"}, n_we - we0, W * H);
        check({tag, "_done_count"}, n_done - done0, 1);
        check({tag, "_shift_count"}, n_shift - sh0, 9 * W * H);
        check({tag, "_sb_left"}, exp_q.size(), 0);
        check({tag, "_idle_state"}, state_reg, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_fetch_addrs"}, addr_log.size(), 9 * W * H);
        base = addr_log.size() - 9;
        if (addr_log.size() >= 9) begin
            for (int i = 0; i < 27; i++) begin
                if (vecs[i].sel == 0) check({tag, "_first_win"}, addr_log[vecs[i].idx], vecs[i].exp);
                if (vecs[i].sel == 1) check({tag, "_last_win"}, addr_log[base + vecs[i].idx], vecs[i].exp);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_state"}, state_reg, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_strobes"}, {28'd0, shift_right, start_conv, out_we, done}, 0);
    endtask

    initial begin
        int fw[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        int lw[9] = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
        int bw[9] = '{0, 1, 2, 130, 131, 132, 260, 261, 262};
        int t, we0, done0, wc;
        for (int i = 0; i < 9; i++) begin
            vecs[i]      = '{0, i, fw[i]};
            vecs[9 + i]  = '{1, i, lw[i]};
            vecs[18 + i] = '{2, i, bw[i]};
        end

        rst_n = 1; b_rst_n = 1; start = 0; b_start = 0; b_done_conv = 0;
        #1;
        rst_n = 0; b_rst_n = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1;
        @(negedge clk);
        check_zero_outputs("idle");

        run(0, "pulse");
        run(1, "held");
        run(2, "midpulse");

        // Reset asserted together with start must keep the FSM idle.
        rst_n = 0; start = 1;
        repeat (2) @(negedge clk);
        check("rst_vs_start_state", state_reg, 0);
        start = 0;
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("rst_vs_start_after", state_reg, 0);
        check("rst_vs_start_busy", busy, 0);

        // Abort during WAIT of window 5, then restart from scratch.
        exp_q.delete();
        for (int i = 0; i < W * H; i++) exp_q.push_back(i);
        we0 = n_we;
        start = 1;
        @(negedge clk);
        start = 0;
        t = 0;
        while (!((n_we - we0) == 5 && state_reg == 3'd4) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort_in_wait", state_reg, 4);
        check("abort_windows_done", n_we - we0, 5);
        #2 rst_n = 0;
        #1;
        check_zero_outputs("async_rst");
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1;
        @(negedge clk);
        run(0, "restart");

        // Default-size instance: first window addresses; WAIT holds with done_conv low.
        b_rst_n = 1;
        @(negedge clk);
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        t = 0;
        while (b_state != 3'd4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("big_in_wait", b_state, 4);
        repeat (20) @(negedge clk);
        check("big_still_wait", b_state, 4);
        check("big_fetch_count", big_log.size(), 9);
        check("big_shift_count", b_shift, 9);
        if (big_log.size() >= 9)
            for (int i = 0; i < 27; i++)
                if (vecs[i].sel == 2) check("big_first_win", big_log[vecs[i].idx], vecs[i].exp);
        b_rst_n = 0;

`ifdef SEQ_TIMEOUT_EN
        // Watchdog: done_conv never returns.
        resp_en = 0;
        done0 = n_done;
        start = 1;
        @(negedge clk);
        start = 0;
        t = 0;
        while (state_reg != 3'd4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        wc = 0;
        while (state_reg == 3'd4 && wc < 50) begin
            wc++;
            @(negedge clk);
        end
        check("wd_wait_cycles", wc, 8);
        check("wd_err", err, 1);
        check("wd_idle", state_reg, 0);
        repeat (3) @(negedge clk);
        check("wd_err_sticky", err, 1);
        check("wd_no_done", n_done - done0, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        check("wd_err_cleared", err, 0);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        resp_en = 1;
        @(negedge clk);
`else
        wc = 0;
        done0 = 0;
        if (wc != done0) $display("watchdog build not selected");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
